// File: rtl/pll_reset_sequencer.sv
// Drives the board PLL RESET pin, qualifies LOCK, then releases per-domain reset
// requests in staged order. Retries on lock timeout and raises a sticky fail when retries run out.
module pll_reset_sequencer #(
  parameter int unsigned NDOM           = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned MAX_RETRY      = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pll_lock,
  input  logic            soft_rst,
  output logic            pll_rst,
  output logic [NDOM-1:0] dom_resetn,
  output logic            ready,
  output logic            fail,
  output logic [7:0]      lock_loss_cnt
);

  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int unsigned MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAXC) + 1;
  localparam int unsigned IW     = (NDOM > 1) ? $clog2(NDOM) : 1;

  localparam logic [CW-1:0] RST_LOAD = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LOAD = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [7:0]             retry_q;
  logic                   pll_rst_q;
  logic [NDOM-1:0]        dom_q;
  logic                   ready_q;
  logic                   fail_q;
  logic [7:0]             llc_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= RST_LOAD;
      idx_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      llc_q     <= '0;
    end else begin
      // A lock drop seen in RUN is counted even when soft_rst wins the same edge.
      if (state_q == S_RUN && !lock_s && llc_q != 8'hFF) llc_q <= llc_q + 8'd1;

      if (soft_rst) begin
        state_q   <= S_PLL_RST;
        cnt_q     <= RST_LOAD;
        retry_q   <= '0;
        pll_rst_q <= 1'b1;
        dom_q     <= '0;
        ready_q   <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        case (state_q)
          S_PLL_RST: begin
            if (cnt_q == '0) begin
              state_q   <= S_WAIT_LOCK;
              cnt_q     <= TO_LOAD;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state_q <= S_STABLE;
              cnt_q   <= STB_LOAD;
            end else if (cnt_q == '0) begin
              pll_rst_q <= 1'b1;
              if (retry_q == 8'(MAX_RETRY)) begin
                state_q <= S_FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= S_PLL_RST;
                cnt_q   <= RST_LOAD;
                retry_q <= retry_q + 8'd1;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              state_q <= S_WAIT_LOCK;
              cnt_q   <= TO_LOAD;
            end else if (cnt_q == '0) begin
              state_q  <= S_RELEASE;
              idx_q    <= '0;
              dom_q[0] <= 1'b1;
              cnt_q    <= (NDOM == 1) ? '0 : GAP_LOAD;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_RELEASE: begin
            // After the last bit the counter is zeroed so ready follows one cycle later.
            if (!lock_s) begin
              state_q   <= S_PLL_RST;
              cnt_q     <= RST_LOAD;
              pll_rst_q <= 1'b1;
              dom_q     <= '0;
            end else if (cnt_q == '0) begin
              if (idx_q == IW'(NDOM - 1)) begin
                state_q <= S_RUN;
                ready_q <= 1'b1;
                retry_q <= '0;
              end else begin
                idx_q <= idx_q + IW'(1);
                dom_q <= dom_q | (NDOM'(1) << (idx_q + IW'(1)));
                cnt_q <= ((idx_q + IW'(1)) == IW'(NDOM - 1)) ? '0 : GAP_LOAD;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_RUN: begin
            if (!lock_s) begin
              state_q   <= S_PLL_RST;
              cnt_q     <= RST_LOAD;
              pll_rst_q <= 1'b1;
              dom_q     <= '0;
              ready_q   <= 1'b0;
            end
          end
          S_FAIL: begin
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            fail_q    <= 1'b1;
          end
          default: begin
            state_q   <= S_PLL_RST;
            cnt_q     <= RST_LOAD;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst       = pll_rst_q;
  assign dom_resetn    = dom_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: elapsed-time phase model compared every cycle,
// directed scenarios pinned with literal timings, then randomized lock/soft_rst traffic.
module tb_pll_reset_sequencer;

  localparam int ND    = 2;
  localparam int SYNC  = 2;
  localparam int RSTC  = 4;
  localparam int TO    = 32;
  localparam int STB   = 8;
  localparam int GAP   = 3;
  localparam int MAXR  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;
  localparam int P_FAIL = 5;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          pll_lock = 1'b0;
  logic          soft_rst = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] dom_resetn;
  logic          ready;
  logic          fail;
  logic [7:0]    lock_loss_cnt;

  pll_reset_sequencer #(
    .NDOM           (ND),
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (RSTC),
    .LOCK_TIMEOUT   (TO),
    .LOCK_STABLE    (STB),
    .STAGE_GAP      (GAP),
    .MAX_RETRY      (MAXR)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .dom_resetn    (dom_resetn),
    .ready         (ready),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: current phase plus cycles elapsed in it; outputs follow from those two.
  int ph      = P_RST;
  int el      = 0;
  int m_retry = 0;
  int m_llc   = 0;
  bit lq[$];

  task automatic m_reset();
    ph = P_RST; el = 0; m_retry = 0; m_llc = 0;
    lq.delete();
    for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
  endtask

  task automatic m_step();
    bit l;
    l = lq.pop_front();
    lq.push_back(pll_lock);
    if (ph == P_RUN && !l && m_llc < 255) m_llc++;
    if (soft_rst) begin
      ph = P_RST; el = 0; m_retry = 0;
    end else begin
      case (ph)
        P_RST:  if (el + 1 == RSTC) begin ph = P_WAIT; el = 0; end else el++;
        P_WAIT: begin
          if (l) begin ph = P_STB; el = 0; end
          else if (el + 1 == TO) begin
            if (m_retry == MAXR) ph = P_FAIL;
            else begin m_retry++; ph = P_RST; end
            el = 0;
          end else el++;
        end
        P_STB: begin
          if (!l) begin ph = P_WAIT; el = 0; end
          else if (el + 1 == STB) begin ph = P_REL; el = 0; end
          else el++;
        end
        P_REL: begin
          if (!l) begin ph = P_RST; el = 0; end
          else if (el + 1 == (ND - 1) * GAP + 1) begin ph = P_RUN; el = 0; m_retry = 0; end
          else el++;
        end
        P_RUN: if (!l) begin ph = P_RST; el = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic int m_dom();
    int d = 0;
    if (ph == P_REL) begin
      for (int k = 0; k < ND; k++) begin
        if (k * GAP <= el) d = d | (1 << k);
      end
    end else if (ph == P_RUN) begin
      d = (1 << ND) - 1;
    end
    return d;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset();
      else         m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("pll_rst",       int'(pll_rst),       int'(ph == P_RST || ph == P_FAIL));
      chk("dom_resetn",    int'(dom_resetn),    m_dom());
      chk("ready",         int'(ready),         int'(ph == P_RUN));
      chk("fail",          int'(fail),          int'(ph == P_FAIL));
      chk("lock_loss_cnt", int'(lock_loss_cnt), m_llc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic wait_ready(input string nm, input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk(nm, int'(ready === 1'b1), 1);
  endtask

  task automatic wait_dom(input string nm, input logic [ND-1:0] v, input int budget);
    int n = 0;
    while (dom_resetn !== v && n < budget) begin @(negedge clk); n++; end
    chk(nm, int'(dom_resetn), int'(v));
  endtask

  initial begin
    int hi, t01, t11, trdy, tf, rises;
    logic prev;

    repeat (3) @(negedge clk);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_dom", int'(dom_resetn), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_llc", int'(lock_loss_cnt), 0);

    // 1: power-up, lock rises 10 cycles after resetn release
    resetn = 1'b1;
    hi = 0;
    for (int j = 0; j < 10; j++) begin hi += int'(pll_rst); @(negedge clk); end
    chk("t1_pll_rst_cycles", hi, 4);
    pll_lock = 1'b1;
    t01 = -1; t11 = -1; trdy = -1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (t01 < 0 && dom_resetn == 2'b01) t01 = j;
      if (t11 < 0 && dom_resetn == 2'b11) t11 = j;
      if (trdy < 0 && ready) trdy = j;
    end
    chk("t1_lat_dom01", t01, 11);
    chk("t1_lat_dom11", t11, 14);
    chk("t1_lat_ready", trdy, 15);
    chk("t1_fail", int'(fail), 0);

    // 2: one-cycle lock glitch during STABLE restarts qualification
    soft_rst = 1'b1;
    hi = 0; t01 = -1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) soft_rst = 1'b0;
      if (j == 8) pll_lock = 1'b0;
      if (j == 9) pll_lock = 1'b1;
      hi += int'(pll_rst);
      if (t01 < 0 && dom_resetn[0]) t01 = j;
    end
    chk("t2_lat_dom01", t01, 20);
    chk("t2_pll_rst_cycles", hi, 4);

    // 3: lock drop in RUN, then saturation of the drop counter
    pll_lock = 1'b0;
    @(negedge clk); pll_lock = 1'b1;
    @(negedge clk);
    chk("t3_dom_held", int'(dom_resetn), 3);
    @(negedge clk);
    chk("t3_dom_drop", int'(dom_resetn), 0);
    chk("t3_ready_drop", int'(ready), 0);
    chk("t3_llc", int'(lock_loss_cnt), 1);
    hi = 0;
    for (int j = 0; j < 10; j++) begin hi += int'(pll_rst); @(negedge clk); end
    chk("t3_pll_rst_pulse", hi, 4);
    wait_ready("t3_reseq_ready", 60);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      @(negedge clk); pll_lock = 1'b1;
      repeat (3) @(negedge clk);
      wait_ready("t3_loop_ready", 60);
    end
    chk("t3_llc_sat", int'(lock_loss_cnt), 255);

    // 4: lock held low: two timeouts with retries, then sticky fail
    pll_lock = 1'b0;
    tf = -1; rises = 0;
    for (int j = 1; j <= 200; j++) begin
      prev = pll_rst;
      @(negedge clk);
      if (fail) begin tf = j; break; end
      if (pll_rst && !prev) rises++;
    end
    chk("t4_fail_time", tf, 111);
    chk("t4_pll_rst_pulses", rises, 3);
    repeat (20) @(negedge clk);
    chk("t4_fail_sticky", int'(fail), 1);
    chk("t4_pll_rst_sticky", int'(pll_rst), 1);
    chk("t4_dom_in_fail", int'(dom_resetn), 0);
    soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0;
    chk("t4_soft_clears_fail", int'(fail), 0);
    chk("t4_soft_pll_rst", int'(pll_rst), 1);
    repeat (3) @(negedge clk);
    chk("t4_pll_rst_last", int'(pll_rst), 1);
    @(negedge clk);
    chk("t4_pll_rst_end", int'(pll_rst), 0);

    // 5: asynchronous reset mid-release
    pll_lock = 1'b1;
    wait_dom("t5_reach_dom01", 2'b01, 80);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_pll_rst", int'(pll_rst), 1);
    chk("t5_async_dom", int'(dom_resetn), 0);
    chk("t5_async_ready", int'(ready), 0);
    chk("t5_async_llc", int'(lock_loss_cnt), 0);
    @(negedge clk); resetn = 1'b1;
    wait_ready("t5_reseq_ready", 100);

    // 6: soft_rst on the same edge the lock drop is seen in RUN
    pll_lock = 1'b0;
    @(negedge clk); pll_lock = 1'b1;
    @(negedge clk); soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0;
    chk("t6_dom", int'(dom_resetn), 0);
    chk("t6_ready", int'(ready), 0);
    chk("t6_llc", int'(lock_loss_cnt), 1);
    repeat (10) @(negedge clk);
    chk("t6_llc_once", int'(lock_loss_cnt), 1);

    // Randomized lock behaviour and soft resets
    for (int i = 0; i < 150; i++) begin
      pll_lock = ($urandom_range(0, 3) != 0);
      soft_rst = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      soft_rst = 1'b0;
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    pll_lock = 1'b1;
    soft_rst = 1'b1;
    @(negedge clk); soft_rst = 1'b0;
    wait_ready("final_ready", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
